// File: rtl/sensor_frame_pkg.sv
// rtl/sensor_frame_pkg.sv - shared frame constants, state type and CRC-8 byte update
package sensor_frame_pkg;

  localparam int FRAME_LEN = 16;
  localparam logic [3:0] IDX_TS   = 4'd2;
  localparam logic [3:0] IDX_DATA = 4'd5;
  localparam logic [3:0] IDX_CSUM = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // CRC-8, poly 0x07, MSB first, no reflection
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sensor_frame_packer_checksum.sv
// rtl/sensor_frame_packer_checksum.sv - running frame check byte; FRAME_CRC_EN selects CRC-8 over modular sum
module frame_checksum
  import sensor_frame_pkg::*;
(
  input  logic       CLK_1MHZ,
  input  logic       RESET,
  input  logic       i_clear,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_result
);

  logic [7:0] r_acc;
  logic [7:0] w_next;

`ifdef FRAME_CRC_EN
  assign w_next = crc8_update(r_acc, i_byte);
`else
  assign w_next = r_acc + i_byte;
`endif

  always_ff @(posedge CLK_1MHZ) begin
    if (RESET || i_clear) begin
      r_acc <= 8'h00;
    end else if (i_byte_en) begin
      r_acc <= w_next;
    end
  end

  assign o_result = r_acc;

endmodule

// File: rtl/sensor_frame_packer.sv
// rtl/sensor_frame_packer.sv - filters stable sensor records and streams them as 16-byte frames
// Optional macro FRAME_CRC_EN: check byte is CRC-8 instead of modular sum.
module sensor_frame_packer
  import sensor_frame_pkg::*;
#(
  parameter int         STABLE_CYCLES = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter logic [7:0] FRAME_TYPE    = 8'h01
) (
  input  logic        CLK_1MHZ,
  input  logic        RESET,
  input  logic [79:0] DATA_IN,
  input  logic [23:0] TIMESTAMP,
  output logic [7:0]  BYTE_OUT,
  output logic        BYTE_VALID,
  input  logic        BYTE_READY,
  output logic        BUSY,
  output logic [7:0]  DROP_COUNT
);

  localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] STAB_QUAL = 4'(STABLE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [79:0] r_prev;
  logic [3:0]  r_stab_cnt;
  logic [79:0] r_last_sent;
  logic        r_pend_valid;
  logic [79:0] r_pend_data;
  logic [23:0] r_pend_ts;
  logic [79:0] r_frame_data;
  logic [23:0] r_frame_ts;
  logic [7:0]  r_drop;

  logic         w_same, w_qualify, w_accept;
  logic         w_xfer, w_last, w_load_new, w_load_pend, w_load, w_csum_en;
  logic [7:0]   w_csum;
  logic [127:0] w_frame_vec;

  assign w_same    = (DATA_IN == r_prev);
  assign w_qualify = w_same && (r_stab_cnt == STAB_QUAL);
  assign w_accept  = w_qualify && (DATA_IN != r_last_sent) &&
                     !(r_pend_valid && (DATA_IN == r_pend_data));

  assign w_xfer      = (r_state == SEND) && BYTE_READY;
  assign w_last      = w_xfer && (r_idx == IDX_CSUM);
  // A record arriving with the last byte and nothing pending is loaded straight away
  assign w_load_new  = w_accept && ((r_state == IDLE) || (w_last && !r_pend_valid));
  assign w_load_pend = w_last && r_pend_valid;
  assign w_load      = w_load_new || w_load_pend;
  assign w_csum_en   = w_xfer && (r_idx != 4'd0) && (r_idx != IDX_CSUM);

  assign w_frame_vec = {SYNC_BYTE, FRAME_TYPE, r_frame_ts, r_frame_data, 8'h00};

  always_ff @(posedge CLK_1MHZ) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_idx        <= 4'd0;
      r_prev       <= '0;
      r_stab_cnt   <= 4'd0;
      r_last_sent  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_pend_ts    <= '0;
      r_frame_data <= '0;
      r_frame_ts   <= '0;
      r_drop       <= 8'h00;
    end else begin
      r_prev <= DATA_IN;
      if (!w_same) begin
        r_stab_cnt <= 4'd0;
      end else if (r_stab_cnt != STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + 4'd1;
      end

      if (w_last) r_last_sent <= r_frame_data;

      if (w_load_new) begin
        r_frame_data <= DATA_IN;
        r_frame_ts   <= TIMESTAMP;
      end else if (w_load_pend) begin
        r_frame_data <= r_pend_data;
        r_frame_ts   <= r_pend_ts;
      end

      if (w_accept && !w_load_new) begin
        r_pend_data <= DATA_IN;
        r_pend_ts   <= TIMESTAMP;
      end
      // Pending emptied this cycle absorbs a new record without counting a drop
      if (w_load_pend) begin
        r_pend_valid <= w_accept;
      end else if (w_accept && !w_load_new) begin
        r_pend_valid <= 1'b1;
        if (r_pend_valid && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end

      if (w_load) begin
        r_state <= SEND;
        r_idx   <= 4'd0;
      end else if (w_last) begin
        r_state <= IDLE;
        r_idx   <= 4'd0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  frame_checksum u_checksum (
    .CLK_1MHZ  (CLK_1MHZ),
    .RESET     (RESET),
    .i_clear   (w_load),
    .i_byte_en (w_csum_en),
    .i_byte    (BYTE_OUT),
    .o_result  (w_csum)
  );

  always_comb begin
    BYTE_OUT = 8'h00;
    if (r_state == SEND) begin
      BYTE_OUT = (r_idx == IDX_CSUM) ? w_csum : w_frame_vec[{~r_idx, 3'b000} +: 8];
    end
  end

  assign BYTE_VALID = (r_state == SEND);
  assign BUSY       = (r_state == SEND);
  assign DROP_COUNT = r_drop;

endmodule
